// File: rtl/uart_pkg.sv
// Shared UART types and constants: FSM state encoding, default timing, line levels.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_bit_timer.sv
// Enable-gated oversample tick counter; bit_done pulses on the last tick of each bit period.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic CLKIN,
    input  logic RESET,
    input  logic clock_enable,
    input  logic clear,
    output logic bit_done
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);

    logic [TW-1:0] tick_q;

    assign bit_done = clock_enable && (tick_q == LAST_TICK);

    always_ff @(posedge CLKIN) begin
        if (RESET || clear) begin
            tick_q <= '0;
        end else if (clock_enable) begin
            tick_q <= bit_done ? '0 : tick_q + TW'(1);
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART serialiser, LSB first, valid/ready input. Define UART_TX_PARITY_EN to insert an
// even-parity bit between the data bits and the stop bit.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 CLKIN,
    input  logic                 RESET,
    input  logic                 clock_enable,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
        return ^b;
    endfunction

    tx_state_t            state_q, state_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_d, ready_d, busy_d;
    logic                 bit_done;
    logic                 xfer;

    assign xfer = valid && ready;

    // Counter is held at zero while idle so every frame starts on a fresh bit period.
    uart_bit_timer #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_bit_timer (
        .CLKIN        (CLKIN),
        .RESET        (RESET),
        .clock_enable (clock_enable),
        .clear        (state_q == IDLE),
        .bit_done     (bit_done)
    );

    always_ff @(posedge CLKIN) begin
        if (RESET) begin
            state_q <= IDLE;
            bit_q   <= '0;
            tx      <= IDLE_LEVEL;
            ready   <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            tx      <= tx_d;
            ready   <= ready_d;
            busy    <= busy_d;
        end
    end

    always_ff @(posedge CLKIN) begin
        shift_q <= shift_d;
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d = START;
                    shift_d = data;
                    bit_d   = '0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_done) state_d = STOP;
            end
            STOP: begin
                if (bit_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered line changes on the transition edge.
    always_comb begin
        tx_d    = IDLE_LEVEL;
        ready_d = 1'b0;
        busy_d  = 1'b1;
        case (state_d)
            IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            START:   tx_d = START_LEVEL;
            DATA:    tx_d = shift_q[bit_d];
            PARITY:  tx_d = even_parity(shift_q);
            default: tx_d = IDLE_LEVEL;
        endcase
    end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- 8N1 UART serialiser that drives the line consumed by uart_receiver. It is the upstream stage of the receive path and is used in loopback benches against it.
- Accepts one byte per valid/ready handshake and shifts it out LSB-first: start bit, 8 data bits, stop bit.
- Bit timing is counted in clock_enable pulses at the same 16x oversample rate the receiver uses. Each bit lasts OVERSAMPLE enabled cycles.

Parameters:
- OVERSAMPLE, 16, clock_enable pulses per bit. Must be at least 2. The uart_receiver pairing requires 16.
- DATA_BITS, 8, payload width. Only 8 is supported when paired with uart_receiver.

Ports:
- CLKIN  input  1  system clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- clock_enable  input  1  oversample tick. Bit timing advances only on cycles where this is high.
- data  input  DATA_BITS  byte to transmit. Sampled on the handshake edge.
- valid  input  1  upstream has a byte.
- ready  output  1  transmitter can accept a byte.
- tx  output  1  serial line, idle high.
- busy  output  1  frame in progress.

Behaviour:
- Reset values: tx=1, ready=1, busy=0, state=IDLE, tick counter=0, bit index=0. Reset wins over every other event on the same edge.
- Reset mid-frame: the frame is abandoned immediately. tx returns to 1 on the next cycle. No partial byte is retried.
- Handshake: a transfer occurs on any CLKIN edge with valid&&ready, regardless of clock_enable. data is latched into the shift register. ready deasserts and busy asserts on that same edge. valid without ready is ignored, and data need not be held afterwards.
- FSM states are IDLE, START, DATA, [PARITY], STOP. All outputs are registered.
  - IDLE: tx=1, ready=1. On transfer, go to START with tick=0; tx=0 from the next cycle.
  - START: tx=0. When tick reaches OVERSAMPLE-1 on an enabled cycle, tick=0, bit=0, go to DATA.
  - DATA: tx=shift[bit]. At the end of each bit (OVERSAMPLE enabled ticks), bit increments. After bit DATA_BITS-1, go to PARITY (when the feature is present) or STOP.
  - STOP: tx=1 for OVERSAMPLE enabled ticks, then IDLE, with ready=1 and busy=0 on the same edge.
- Tick counter: width clog2(OVERSAMPLE). It increments only when clock_enable=1 and wraps to 0 at OVERSAMPLE-1.
- Frame length: exactly 10*OVERSAMPLE enabled cycles (11*OVERSAMPLE with parity).
- Back-to-back frames: if valid is held high, the next start bit begins one CLKIN cycle after ready reasserts. No extra idle bit is inserted.
- clock_enable held low: the FSM freezes and tx holds its value. A handshake is still accepted in IDLE.
- Changes to data or valid during a frame have no effect.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. tx carries the even parity bit (XOR of the latched byte) for OVERSAMPLE ticks.
- Undefined: no PARITY state, pure 8N1.
- uart_receiver does not understand parity, so loopback benches require the macro to be undefined.

Decomposition:
- uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - the default constants OVERSAMPLE=16 and DATA_BITS=8;
  - the line levels IDLE_LEVEL=1 and START_LEVEL=0.
- One sub-module, uart_bit_timer. It contains the enable-gated tick counter, takes a clear input, and outputs a bit_done pulse. The future receiver rewrite reuses it.

Test Plan:
- Reset, then idle with clock_enable=1 -> tx=1, ready=1, busy=0 held for 100 cycles.
- Send 0xA5 with clock_enable tied high -> tx is 0,1,0,1,0,0,1,0,1,1, each level lasting exactly 16 cycles; ready returns high at cycle 160 after the handshake.
- Send 0x3C with clock_enable high one cycle in four -> every bit lasts 64 CLKIN cycles; frame length is 640 cycles.
- valid held high with bytes 0x00 then 0xFF -> two frames with exactly one cycle of idle tx=1 between the stop bit and the next start bit.
- Assert RESET during data bit 3 of 0x81 -> tx=1 on the next cycle, ready=1, busy=0; a new byte 0x55 then transmits correctly.
- Loopback to uart_receiver with ready=1 (parity disabled), bytes 0x00, 0x5A, 0xFF -> the receiver pulses valid once per byte with matching data.
